rr_grant_sequencer: RTL
=======================

Name: rr_grant_sequencer

Overview:
- Round-robin arbiter that shares one resource between 2**N requesters. The owner is steered by a one-hot select.
- The block holds a registered owner index and drives the one-hot grant through the generic binary-to-one-hot decoder (decoder_generic, enable = grant_valid).
- Adds a grant-hold timeout so that one requester cannot starve the others.
- Sits between the requester ports and the shared datapath mux/enable.

Parameters:
- N, 2, index width; number of requesters = 2**N.
- MAX_HOLD, 16, maximum cycles a grant may be held before forced revocation; range 1..2**16-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2**N  per-requester request, level.
- release  input  1  current owner frees the resource (sampled only in GRANT).
- grant  output  2**N  one-hot grant (decoder of grant_id, gated by grant_valid).
- grant_id  output  N  binary index of the current owner.
- grant_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-revoked.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset. All state is updated on the rising edge of clk.
- Reset values:
  - state = IDLE; grant_valid = 0; grant = 0; grant_id = 0.
  - ptr = 0, where ptr is the round-robin start index.
  - hold_cnt = 0; timeout = 0.
  - reset has priority over every other input, including mid-grant.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ... with wrap modulo 2**N.
  - Register that bit's index into grant_id, set grant_valid = 1, and go to GRANT.
  - Latency: req asserted in cycle t gives grant visible in cycle t+1.
  - If req == 0, stay in IDLE.
- GRANT:
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - If release = 1, or req[grant_id] = 0: drop the grant next cycle, set ptr = grant_id+1 (wrap), clear hold_cnt, and go to IDLE.
  - Else if hold_cnt == MAX_HOLD-1: force-revoke. Pulse timeout = 1 for one cycle, set ptr = grant_id+1, clear hold_cnt, and go to GAP.
  - release and timeout in the same cycle: release wins, and no timeout pulse is generated.
- GAP:
  - Lasts exactly one cycle with grant_valid = 0, then goes to IDLE.
  - Guarantees a dead cycle on the resource after forced revocation.
- Grant-to-grant spacing:
  - Minimum one idle cycle between consecutive grants via the IDLE re-arbitration cycle.
  - Two cycles after a timeout (GAP + IDLE).
- Pointer arithmetic:
  - ptr is N bits and wraps naturally (index 2**N-1 + 1 = 0).
  - The scan uses a doubled request vector {req,req} shifted by ptr, or an equivalent priority scheme.
- grant is purely combinational from the registered grant_id/grant_valid through the decoder. It is therefore glitch-free relative to clk and is always zero or exactly one-hot.
- req changes on non-owner bits during GRANT have no effect.
- A requester winning again immediately is allowed only if it is the sole requester.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, GRANT=2'd1, GAP=2'd2) and the hold-counter width, computed as clog2(MAX_HOLD+1).
- Sub-module: the existing decoder_generic (n = N) is instantiated for grant generation.
- The round-robin priority scan stays inline in this block as a combinational function.

Test Plan:
- Reset: assert reset for 2 cycles with req=4'b1111 -> grant=0, grant_valid=0, timeout=0. First grant after deassert is grant_id=0, grant=4'b0001.
- Round robin: hold req=4'b1111 and pulse release 2 cycles after each grant -> grant_id sequence 0,1,2,3,0 with one idle cycle between grants.
- Wrap and skip: ptr=3 (after granting 2), req=4'b0101 -> next grant_id=0 (wrap), then grant_id=2.
- Timeout: MAX_HOLD=4, req=4'b0010 held, no release -> grant_valid high for 4 cycles, timeout pulses once, 1-cycle GAP, then regrant to id 1.
- Simultaneous release/timeout: release asserted in the cycle hold_cnt==MAX_HOLD-1 -> no timeout pulse, normal return to IDLE.
- Mid-operation reset: assert reset while in GRANT with id=2 -> next cycle grant=0 and ptr=0. Re-arbitration with req=4'b1100 grants id 2.

Source files
------------

// File: rtl/rr_grant_sequencer_pkg.sv
// Shared definitions for the round-robin grant sequencer: FSM encoding and
// the hold-counter sizing helper.
package rr_grant_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } rr_state_e;

   // Counter must be able to represent MAX_HOLD itself (saturation value).
   function automatic int hold_width(input int max_hold);
      return $clog2(max_hold + 1);
   endfunction

endpackage

// File: rtl/rr_grant_sequencer_decoder.sv
// Generic binary-to-one-hot decoder with enable; output is all zero when
// disabled, otherwise exactly one bit set.
module decoder_generic #(
   parameter int n = 2
) (
   input  logic              en,
   input  logic [n-1:0]      sel,
   output logic [2**n-1:0]   onehot
);

   // Decode the binary select into a single set bit.
   always_comb begin
      onehot = {(2**n){1'b0}};
      if (en) begin
         onehot[sel] = 1'b1;
      end else begin
         onehot = {(2**n){1'b0}};
      end
   end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter for 2**N requesters with a grant-hold timeout and a
// dead cycle after forced revocation. The owner's free input is named
// release_grant because release is a reserved word.
module rr_grant_sequencer
   import rr_grant_sequencer_pkg::*;
#(
   parameter int N        = 2,
   parameter int MAX_HOLD = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [2**N-1:0] req,
   input  logic            release_grant,
   output logic [2**N-1:0] grant,
   output logic [N-1:0]    grant_id,
   output logic            grant_valid,
   output logic            timeout
);

   localparam int NREQ = 2**N;
   localparam int HW   = hold_width(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);

   rr_state_e         state_r, state_s;
   logic [N-1:0]      grant_id_r, grant_id_s;
   logic [N-1:0]      ptr_r, ptr_s;
   logic [HW-1:0]     hold_cnt_r, hold_cnt_s;
   logic              grant_valid_r, timeout_r, timeout_s;

   // First set request bit scanning upward from p, wrapping modulo 2**N.
   function automatic logic [N-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [N-1:0]    p);
      logic [N-1:0] idx;
      logic         found;
      rr_pick = p;
      found   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = p + i[N-1:0];
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end else begin
            found   = found;
         end
      end
   endfunction

   // Next-state and next-value logic for the arbitration FSM.
   always_comb begin
      state_s    = state_r;
      grant_id_s = grant_id_r;
      ptr_s      = ptr_r;
      hold_cnt_s = hold_cnt_r;
      timeout_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (req != {NREQ{1'b0}}) begin
               grant_id_s = rr_pick(req, ptr_r);
               hold_cnt_s = {HW{1'b0}};
               state_s    = GRANT;
            end else begin
               state_s    = IDLE;
            end
         end
         GRANT: begin
            // Release beats timeout, so a same-cycle release never pulses.
            if (release_grant || !req[grant_id_r]) begin
               ptr_s      = grant_id_r + N'(1'b1);
               hold_cnt_s = {HW{1'b0}};
               state_s    = IDLE;
            end else if (hold_cnt_r == HOLD_LAST) begin
               ptr_s      = grant_id_r + N'(1'b1);
               hold_cnt_s = {HW{1'b0}};
               timeout_s  = 1'b1;
               state_s    = GAP;
            end else if (hold_cnt_r < HOLD_MAX) begin
               hold_cnt_s = hold_cnt_r + HW'(1'b1);
            end else begin
               hold_cnt_s = hold_cnt_r;
            end
         end
         GAP: begin
            state_s = IDLE;
         end
         default: begin
            hold_cnt_s = {HW{1'b0}};
            state_s    = IDLE;
         end
      endcase
   end

   // State and output registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         grant_id_r    <= {N{1'b0}};
         ptr_r         <= {N{1'b0}};
         hold_cnt_r    <= {HW{1'b0}};
         grant_valid_r <= 1'b0;
         timeout_r     <= 1'b0;
      end else begin
         state_r       <= state_s;
         grant_id_r    <= grant_id_s;
         ptr_r         <= ptr_s;
         hold_cnt_r    <= hold_cnt_s;
         grant_valid_r <= (state_s == GRANT);
         timeout_r     <= timeout_s;
      end
   end

   decoder_generic #(.n(N)) u_grant_dec (
      .en     (grant_valid_r),
      .sel    (grant_id_r),
      .onehot (grant)
   );

   assign grant_id    = grant_id_r;
   assign grant_valid = grant_valid_r;
   assign timeout     = timeout_r;

endmodule
